req_ack_responder_fifo: RTL and testbench

- Responder end of the req/ack pull handshake used by the async operators.
- Buffers data pushed in by a local writer.
- Answers downstream `req` from one or more consumers with a one-cycle `ack` pulse plus registered data.
- Sits where a producer would: a buffered, fan-out-capable data source feeding operator `req_l`/`ack_l` inputs or bench consumers.

---
 rtl/req_ack_responder_fifo.sv | 85 ++++++++
 tb/tb_req_ack_responder_fifo.sv | 164 ++++++++++++++++
 2 files changed

// File: rtl/req_ack_responder_fifo.sv
// req_ack_responder_fifo
//
// Responder end of the req/ack pull handshake. A local writer pushes words
// into a small FIFO; once every consumer raises its req line, the oldest word
// is presented on dout together with a one-cycle ack pulse.
//
// Ports:
//   clk       rising-edge clock
//   rst       asynchronous active-low reset
//   wr_en     push strobe from the local writer
//   wr_data   word to push
//   full      occupancy equals depth
//   empty     occupancy is zero
//   level     current occupancy
//   overflow  sticky flag, set when a push had to be dropped
//   req       per-consumer request lines, all must be high to pop
//   ack       registered one-cycle acknowledge pulse
//   dout      registered data, updated with each ack and held in between
//   count     total number of acks issued (wraps modulo 2^32)
module req_ack_responder_fifo #(
  parameter int data_width  = 32,
  parameter int depth       = 4,
  parameter int output_size = 1
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       wr_en,
  input  logic [data_width-1:0]      wr_data,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(depth):0]     level,
  output logic                       overflow,
  input  logic [output_size-1:0]     req,
  output logic                       ack,
  output logic [data_width-1:0]      dout,
  output logic [31:0]                count
);

  localparam int AW = $clog2(depth);
  localparam int LW = AW + 1;

  logic [data_width-1:0] mem [depth];
  logic [AW-1:0]         rd_ptr;
  logic [AW-1:0]         wr_ptr;
  logic                  pop;
  logic                  push;

  // Occupancy is tracked explicitly, so full/empty stay unambiguous across
  // pointer wraps without an extra pointer bit.
  assign full  = (level == LW'(depth));
  assign empty = (level == '0);

  // Gating on the previous ack enforces a two-cycle minimum ack spacing.
  assign pop  = (&req) & ~ack & ~empty;
  // A pop in the same edge frees a slot, so a push at full is still accepted.
  assign push = wr_en & (~full | pop);

  // Storage carries no reset; its contents are meaningless until written.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= wr_data;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ack      <= 1'b0;
      dout     <= '0;
      count    <= '0;
      overflow <= 1'b0;
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      level    <= '0;
    end else begin
      ack <= pop;
      if (pop) begin
        dout   <= mem[rd_ptr];
        rd_ptr <= rd_ptr + 1'b1;
        count  <= count + 32'd1;
      end
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (wr_en && !push) overflow <= 1'b1;
      level <= level + LW'(push) - LW'(pop);
    end
  end

endmodule

// File: tb/tb_req_ack_responder_fifo.sv
module tb_req_ack_responder_fifo;

  localparam int DW = 32;
  localparam int DEPTH = 4;
  localparam int NREQ = 2;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          wr_en = 1'b0;
  logic [DW-1:0] wr_data = '0;
  logic          full, empty, overflow, ack;
  logic [2:0]    level;
  logic [NREQ-1:0] req = '0;
  logic [DW-1:0] dout;
  logic [31:0]   count;

  int n_vec = 0;
  int n_fail = 0;

  // Reference model: a queue of accepted words plus a few scalars.
  logic [DW-1:0] m_q[$];
  logic [DW-1:0] exp_q[$];
  logic          m_ack = 1'b0;
  logic [DW-1:0] m_dout = '0;
  logic [31:0]   m_count = '0;
  logic          m_ovf = 1'b0;

  req_ack_responder_fifo #(
    .data_width(DW), .depth(DEPTH), .output_size(NREQ)
  ) dut (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_data(wr_data),
    .full(full), .empty(empty), .level(level), .overflow(overflow),
    .req(req), .ack(ack), .dout(dout), .count(count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_vec++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, expv, $time);
    end
  endtask

  task automatic check_state();
    chk("ack",      32'(ack),      32'(m_ack));
    chk("dout",     dout,          m_dout);
    chk("level",    32'(level),    32'(m_q.size()));
    chk("full",     32'(full),     32'(m_q.size() == DEPTH));
    chk("empty",    32'(empty),    32'(m_q.size() == 0));
    chk("overflow", 32'(overflow), 32'(m_ovf));
    chk("count",    count,         m_count);
  endtask

  // One cycle: verify current outputs, predict the next edge, apply inputs.
  task automatic step(input logic we, input logic [DW-1:0] d, input logic [NREQ-1:0] r);
    logic p;
    @(negedge clk);
    check_state();
    p = (&r) && !m_ack && (m_q.size() > 0);
    if (p) begin
      m_dout = m_q.pop_front();
      exp_q.push_back(m_dout);
      m_count++;
    end
    if (we) begin
      if (m_q.size() < DEPTH) m_q.push_back(d);
      else m_ovf = 1'b1;
    end
    m_ack = p;
    wr_en = we; wr_data = d; req = r;
  endtask

  task automatic model_reset();
    m_q.delete(); exp_q.delete();
    m_ack = 1'b0; m_dout = '0; m_count = '0; m_ovf = 1'b0;
  endtask

  task automatic mid_reset();
    @(negedge clk);
    check_state();
    wr_en = 1'b0; req = '0;
    #2 rst = 1'b0;
    #1;
    chk("rst_ack",   32'(ack),   32'd0);
    chk("rst_level", 32'(level), 32'd0);
    chk("rst_count", count,      32'd0);
    chk("rst_dout",  dout,       32'd0);
    model_reset();
    @(negedge clk);
    rst = 1'b1;
  endtask

  // Monitor: every ack must match the oldest predicted word.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (rst && ack) begin
        if (exp_q.size() == 0) begin
          n_vec++; n_fail++;
          $display("FAIL spurious_ack: got dout %0h expected no ack at %0t", dout, $time);
        end else begin
          chk("ack_data", dout, exp_q.pop_front());
        end
      end
    end
  end

  initial begin
    repeat (3) @(negedge clk);
    rst = 1'b1;

    // Basic: three pushes, req held high.
    step(1, 10, 2'b11); step(1, 11, 2'b11); step(1, 12, 2'b11);
    repeat (6) step(0, 0, 2'b11);

    // Fan-out: partial request never pops.
    step(1, 7, 2'b00);
    repeat (5) step(0, 0, 2'b01);
    step(0, 0, 2'b11); step(0, 0, 2'b11); step(0, 0, 2'b00);

    // Full / overflow.
    for (int i = 1; i <= 5; i++) step(1, 32'(i), 2'b00);
    step(0, 0, 2'b00);
    repeat (9) step(0, 0, 2'b11);

    // Async reset mid-stream with three words buffered.
    for (int i = 0; i < 3; i++) step(1, 32'(20 + i), 2'b00);
    step(0, 0, 2'b00);
    mid_reset();
    repeat (4) step(0, 0, 2'b11);

    // Push at full in the same edge as a pop.
    for (int i = 0; i < 4; i++) step(1, 32'(40 + i), 2'b00);
    step(1, 99, 2'b11);
    repeat (10) step(0, 0, 2'b11);

    // Pointer wrap: ten words streamed through.
    for (int i = 0; i < 10; i++) begin
      step(1, 32'(i), 2'b11);
      step(0, 0, 2'b11);
    end
    repeat (4) step(0, 0, 2'b11);

    // Randomized traffic.
    for (int i = 0; i < 400; i++) begin
      logic we;
      logic [NREQ-1:0] r;
      we = ($urandom_range(0, 99) < 55);
      r  = ($urandom_range(0, 3) != 0) ? 2'b11 : NREQ'($urandom_range(0, 3));
      step(we, $urandom, r);
    end
    repeat (12) step(0, 0, 2'b11);
    @(negedge clk);
    check_state();
    chk("drained", 32'(exp_q.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
